// File: rtl/knights_pkg.sv
// Shared constants and types for the command/response UART wrapper.
package knights_pkg;

  localparam int unsigned BAUD_DIV_DEF = 2604;
  localparam int unsigned TIMEOUT_DEF  = 1_000_000;
  localparam int unsigned FRAME_BITS   = 10;

  typedef enum logic {
    IDLE     = 1'b0,
    LOW_WAIT = 1'b1
  } cmd_state_t;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } cmd_t;

endpackage

// File: rtl/uart_wrapper_uart.sv
// 8N1 UART: independent receiver and transmitter sharing one clock.
module UART
  import knights_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = $clog2(BAUD_DIV + 1);
  localparam int unsigned BIT_W  = 4;

  // ---------------- transmitter ----------------
  logic [9:0]        tx_shft;
  logic [BAUD_W-1:0] tx_baud;
  logic [BIT_W-1:0]  tx_bits;
  logic              tx_busy;
  logic              tx_baud_end_c;

  assign tx_baud_end_c = (tx_baud == BAUD_W'(BAUD_DIV - 1));

  // Shift register idles all-ones so TX rests high; trmt is ignored while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '1;
      tx_baud <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else if (trmt && !tx_busy) begin
      tx_shft <= {1'b1, tx_data, 1'b0};
      tx_baud <= '0;
      tx_bits <= '0;
      tx_busy <= 1'b1;
      tx_done <= 1'b0;
    end else if (tx_busy) begin
      if (tx_baud_end_c) begin
        tx_baud <= '0;
        tx_shft <= {1'b1, tx_shft[9:1]};
        tx_bits <= tx_bits + BIT_W'(1);
        if (tx_bits == BIT_W'(FRAME_BITS - 1)) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end
      end else begin
        tx_baud <= tx_baud + BAUD_W'(1);
      end
    end
  end

  assign TX = tx_shft[0];

  // ---------------- receiver ----------------
  logic              rx_ff1, rx_ff2;
  logic [7:0]        rx_shft;
  logic [BAUD_W-1:0] rx_baud;
  logic [BIT_W-1:0]  rx_bits;
  logic              rx_busy;
  logic              rx_start_c, rx_sample_c, rx_done_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1 <= 1'b1;
      rx_ff2 <= 1'b1;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
    end
  end

  assign rx_start_c  = !rx_busy && !rx_ff2;
  assign rx_sample_c = rx_busy && (rx_baud == '0);
  assign rx_done_c   = rx_sample_c && (rx_bits == BIT_W'(FRAME_BITS - 1)) && rx_ff2;

  // Samples mid-bit; a start bit that is high again at its midpoint is dropped as a glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy <= 1'b0;
      rx_baud <= '0;
      rx_bits <= '0;
      rx_shft <= '0;
    end else if (rx_start_c) begin
      rx_busy <= 1'b1;
      rx_baud <= BAUD_W'(BAUD_DIV / 2);
      rx_bits <= '0;
    end else if (rx_sample_c) begin
      rx_baud <= BAUD_W'(BAUD_DIV - 1);
      rx_bits <= rx_bits + BIT_W'(1);
      if (rx_bits != '0 && rx_bits != BIT_W'(FRAME_BITS - 1))
        rx_shft <= {rx_ff2, rx_shft[7:1]};
      if ((rx_bits == '0 && rx_ff2) || rx_bits == BIT_W'(FRAME_BITS - 1))
        rx_busy <= 1'b0;
    end else if (rx_busy) begin
      rx_baud <= rx_baud - BAUD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         rx_rdy <= 1'b0;
    else if (rx_done_c)                 rx_rdy <= 1'b1;
    else if (clr_rx_rdy || rx_start_c)  rx_rdy <= 1'b0;
  end

  assign rx_data = rx_shft;

endmodule

// File: rtl/uart_wrapper.sv
// Assembles two received bytes (high first) into a 16-bit command and
// forwards single response bytes to the UART transmitter.
module uart_wrapper
  import knights_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  logic             rx_rdy;
  logic [7:0]       rx_data;
  logic             clr_rx_rdy_c;
  cmd_state_t       state, nxt_state;
  cmd_t             cmd_q;
  logic [TMR_W-1:0] tmr;
  logic             cap_hi_c, cap_lo_c, tmr_inc_c;

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy_c),
    .rx_data    (rx_data),
    .trmt       (trmt),
    .tx_data    (resp),
    .tx_done    (tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Byte-pair assembly; a stale high byte is abandoned when the timer expires.
  always_comb begin
    nxt_state    = state;
    clr_rx_rdy_c = 1'b0;
    cap_hi_c     = 1'b0;
    cap_lo_c     = 1'b0;
    tmr_inc_c    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_rdy) begin
          clr_rx_rdy_c = 1'b1;
          cap_hi_c     = 1'b1;
          nxt_state    = LOW_WAIT;
        end
      end
      LOW_WAIT: begin
        if (rx_rdy) begin
          clr_rx_rdy_c = 1'b1;
          cap_lo_c     = 1'b1;
          nxt_state    = IDLE;
        end else if (tmr == TMR_W'(TIMEOUT - 1)) begin
          nxt_state = IDLE;
        end else begin
          tmr_inc_c = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tmr <= '0;
    else if (tmr_inc_c) tmr <= tmr + TMR_W'(1);
    else                tmr <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
    end else begin
      if (cap_hi_c) cmd_q.hi <= rx_data;
      if (cap_lo_c) cmd_q.lo <= rx_data;
    end
  end

  // Completion of a pair beats a coincident consumer acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cmd_rdy <= 1'b0;
    else if (cap_lo_c)                  cmd_rdy <= 1'b1;
    else if (cap_hi_c || clr_cmd_rdy)   cmd_rdy <= 1'b0;
  end

  assign cmd = cmd_q;

endmodule

// File: tb/tb_uart_wrapper.sv
// Scoreboard bench: stimulus pushes expected commands/response bytes, monitors pop and compare.
module tb_uart_wrapper;

  localparam int B       = 16;
  localparam int TIMEOUT = 400;
  localparam int FRAME   = 10 * B;

  logic        clk, rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done;
  logic [15:0] cmd;
  logic [7:0]  resp;

  uart_wrapper #(.BAUD_DIV(B), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks, n_pass;
  int          rises, exp_rises, rst_epoch;
  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];
  bit          have_high;
  logic [7:0]  hi_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_serial(input logic [7:0] b);
    RX = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(B);
    end
    RX = 1'b1;
    tick(B);
  endtask

  // Reference rule: a byte completes a pair only if a high byte is pending and
  // it finished arriving within TIMEOUT clocks of that high byte.
  task automatic rx_byte(input logic [7:0] b, input int gap, input bit hold_clr);
    bit done;
    tick(gap);
    if (have_high && (gap + FRAME < TIMEOUT)) begin
      exp_q.push_back({hi_byte, b});
      exp_rises++;
      have_high = 1'b0;
      done = 1'b1;
    end else begin
      hi_byte   = b;
      have_high = 1'b1;
      done = 1'b0;
    end
    if (hold_clr) clr_cmd_rdy = 1'b1;
    send_serial(b);
    if (done) begin
      tick(3);
      #1;
      check("cmd_rdy_latency", rises, exp_rises);
    end
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic do_tx(input logic [7:0] b, input bit ign);
    int ign_at;
    ign_at = ign ? int'($urandom_range(10, FRAME - 12)) : -1;
    resp = b;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    tx_q.push_back(b);
    check("tx_done_clear", tx_done, 0);
    for (int i = 0; i < FRAME - 1; i++) begin
      if (i == ign_at) begin
        resp = ~b;
        trmt = 1'b1;
      end else begin
        trmt = 1'b0;
      end
      @(negedge clk);
    end
    trmt = 1'b0;
    check("tx_done_early", tx_done, 0);
    tick(2);
    check("tx_done_set", tx_done, 1);
  endtask

  // Command monitor: pops an expectation on each cmd_rdy rise, checks cmd holds while high.
  logic        mon_prev, mon_bad;
  logic [15:0] mon_held;
  initial begin
    mon_prev = 1'b0;
    mon_bad  = 1'b0;
    mon_held = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_prev = 1'b0;
      end else begin
        if (cmd_rdy === 1'b1 && !mon_prev) begin
          rises++;
          if (exp_q.size() == 0) fail_now("cmd_unexpected_rdy", {16'h0, cmd});
          else check("cmd_value", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
          mon_held = cmd;
          mon_bad  = 1'b0;
        end else if (cmd_rdy === 1'b1 && mon_prev) begin
          if (cmd !== mon_held) mon_bad = 1'b1;
        end else if (mon_prev) begin
          check("cmd_stable_while_rdy", mon_bad, 0);
        end
        mon_prev = (cmd_rdy === 1'b1);
      end
    end
  end

  // TX line decoder: mid-bit sampling of each frame, compared with queued response bytes.
  logic       dec_prev, dec_ok;
  logic [7:0] dec_got;
  int         dec_ep;
  initial begin
    dec_prev = 1'b1;
    dec_ok   = 1'b0;
    dec_got  = '0;
    dec_ep   = 0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && dec_prev === 1'b1 && TX === 1'b0) begin
        dec_ep = rst_epoch;
        repeat (B / 2) @(negedge clk);
        dec_ok = (TX === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (B) @(negedge clk);
          dec_got[i] = TX;
        end
        repeat (B) @(negedge clk);
        dec_ok = dec_ok && (TX === 1'b1);
        if (dec_ep == rst_epoch) begin
          if (tx_q.size() == 0) fail_now("tx_unexpected_frame", {24'h0, dec_got});
          else check("tx_frame", {23'h0, dec_ok, dec_got}, {23'h0, 1'b1, tx_q.pop_front()});
        end
      end
      dec_prev = TX;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_pass = 0; rises = 0; exp_rises = 0; rst_epoch = 0;
    have_high = 1'b0; hi_byte = '0;
    rst_n = 1'b0; RX = 1'b1; clr_cmd_rdy = 1'b0; trmt = 1'b0; resp = '0;
    tick(3);
    check("reset_cmd", {16'h0, cmd}, 0);
    check("reset_cmd_rdy", cmd_rdy, 0);
    check("reset_tx", TX, 1);
    check("reset_tx_done", tx_done, 0);
    rst_n = 1'b1;
    tick(5);

    // 0x2F,0x01 then acknowledge
    rx_byte(8'h2F, 10, 1'b0);
    rx_byte(8'h01, 10, 1'b0);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    check("clr_cmd_rdy", cmd_rdy, 0);
    check("cmd_held_after_clr", {16'h0, cmd}, 32'h2F01);

    // two zero pairs with no acknowledge
    rx_byte(8'h00, 20, 1'b0);
    rx_byte(8'h00, 5, 1'b0);
    rx_byte(8'h00, 5, 1'b0);
    check("rdy_drop_on_new_high", cmd_rdy, 0);
    rx_byte(8'h00, 5, 1'b0);

    // acknowledge held across low-byte completion: set wins
    rx_byte(8'hAB, 20, 1'b0);
    rx_byte(8'hCD, 20, 1'b1);

    // orphan high byte times out
    rx_byte(8'h40, 20, 1'b0);
    rx_byte(8'h12, TIMEOUT + 10, 1'b0);
    rx_byte(8'h34, 8, 1'b0);
    check("cmd_after_timeout", {16'h0, cmd}, 32'h1234);

    // response with an ignored mid-frame trmt
    do_tx(8'hA5, 1'b1);
    tick(10);

    // reset in the middle of a low byte and of a transmission
    rx_byte(8'h3F, 10, 1'b0);
    tick(10);
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    RX = 1'b0;
    tick(B);
    for (int i = 0; i < 4; i++) begin
      RX = (i == 0);
      tick(B);
    end
    rst_n = 1'b0;
    rst_epoch++;
    RX = 1'b1;
    have_high = 1'b0;
    #1;
    check("midreset_tx_high", TX, 1);
    check("midreset_cmd", {16'h0, cmd}, 0);
    check("midreset_cmd_rdy", cmd_rdy, 0);
    check("midreset_tx_done", tx_done, 0);
    tick(4);
    rst_n = 1'b1;
    rx_byte(8'h2B, 20, 1'b0);
    rx_byte(8'hF1, 10, 1'b0);
    check("cmd_after_reset", {16'h0, cmd}, 32'h2BF1);

    // concurrent randomized receive and transmit traffic
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          int gap;
          gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 450))
                                            : int'($urandom_range(0, 150));
          rx_byte(8'($urandom), gap, ($urandom_range(0, 4) == 0));
        end
      end
      begin
        for (int k = 0; k < 6; k++) begin
          tick(int'($urandom_range(5, 60)));
          do_tx(8'($urandom), 1'($urandom_range(0, 1)));
        end
      end
    join

    tick(FRAME);
    check("cmd_queue_empty", exp_q.size(), 0);
    check("tx_queue_empty", tx_q.size(), 0);
    check("cmd_rdy_rise_count", rises, exp_rises);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
